// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style core: reset/base address, word stride and
// memory access-size encodings.
package mips_pkg;

  localparam logic [31:0] StartAddress = 32'h8002_0000;
  localparam int unsigned WordStride = 4;

  typedef enum logic [1:0] {
    AccSize1  = 2'b00,
    AccSize4  = 2'b01,
    AccSize8  = 2'b10,
    AccSize16 = 2'b11
  } acc_size_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with push, pop and synchronous flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two sized, so natural overflow gives the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (do_pop && !do_push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential single-word reads to main memory, buffers the
// returned words with their PCs, and flushes on branch redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned             ADDRESS_SIZE  = 32,
  parameter int unsigned             DATA_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = ADDRESS_SIZE'(StartAddress),
  parameter int unsigned             DEPTH         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch_valid,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  input  logic                    insn_ready,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [1:0]              mem_acc_size,
  output logic [DATA_SIZE-1:0]    insn_out,
  output logic [ADDRESS_SIZE-1:0] pc_out,
  output logic                    insn_valid
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = ADDRESS_SIZE + DATA_SIZE;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] Stride = ADDRESS_SIZE'(WordStride);
  localparam logic [ADDRESS_SIZE-1:0] AlignMask = ~ADDRESS_SIZE'(3);

  logic [ADDRESS_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_en_q, mem_en_d;
  logic                    inflight_q, inflight_d;
  logic [ADDRESS_SIZE-1:0] last_pc_q, last_pc_d;
  logic [DATA_SIZE-1:0]    last_insn_q, last_insn_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_count;
  logic [EntryW-1:0]       fifo_wdata, fifo_rdata;
  logic [ADDRESS_SIZE-1:0] head_pc;
  logic [DATA_SIZE-1:0]    head_insn;
  logic [CntW:0]           occupancy;
  logic                    issue;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (branch_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_pc   = fifo_rdata[EntryW-1 -: ADDRESS_SIZE];
  assign head_insn = fifo_rdata[DATA_SIZE-1:0];

  // Reserve a slot for the outstanding read so its data always has room on return.
  assign occupancy = {1'b0, fifo_count} + (CntW + 1)'(inflight_q);
  assign issue     = !branch_valid && (occupancy < DepthOcc);

  assign fifo_wdata = {mem_addr_q, mem_d_out};
  assign fifo_push  = inflight_q && !branch_valid && !fifo_full;
  assign fifo_pop   = !fifo_empty && insn_ready && !branch_valid;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    mem_addr_d  = mem_addr_q;
    mem_en_d    = 1'b0;
    inflight_d  = 1'b0;
    last_pc_d   = last_pc_q;
    last_insn_d = last_insn_q;
    if (!fifo_empty) begin
      last_pc_d   = head_pc;
      last_insn_d = head_insn;
    end
    if (branch_valid) begin
      fetch_pc_d = branch_target & AlignMask;
    end else if (issue) begin
      mem_addr_d = fetch_pc_q;
      mem_en_d   = 1'b1;
      inflight_d = 1'b1;
      fetch_pc_d = fetch_pc_q + Stride;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= START_ADDRESS;
      mem_addr_q  <= START_ADDRESS;
      mem_en_q    <= 1'b0;
      inflight_q  <= 1'b0;
      last_pc_q   <= '0;
      last_insn_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_en_q    <= mem_en_d;
      inflight_q  <= inflight_d;
      last_pc_q   <= last_pc_d;
      last_insn_q <= last_insn_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_en       = mem_en_q;
  assign mem_wren     = 1'b0;
  assign mem_acc_size = AccSize1;
  assign insn_valid   = !fifo_empty;
  assign pc_out       = fifo_empty ? last_pc_q : head_pc;
  assign insn_out     = fifo_empty ? last_insn_q : head_insn;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model and a
// randomized in-order delivery scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] Base = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        insn_ready = 1'b0;
  logic [31:0] mem_d_out = '0;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_wren;
  logic [1:0]  mem_acc_size;
  logic [31:0] insn_out;
  logic [31:0] pc_out;
  logic        insn_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDRESS_SIZE  (32),
    .DATA_SIZE     (32),
    .START_ADDRESS (Base),
    .DEPTH         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .insn_ready    (insn_ready),
    .mem_d_out     (mem_d_out),
    .mem_addr      (mem_addr),
    .mem_en        (mem_en),
    .mem_wren      (mem_wren),
    .mem_acc_size  (mem_acc_size),
    .insn_out      (insn_out),
    .pc_out        (pc_out),
    .insn_valid    (insn_valid)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Memory samples the registered address on the falling edge.
  always @(negedge clk) begin
    if (mem_en) mem_d_out <= mem_val(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    branch_valid = 1'b0;
    insn_ready = 1'b0;
    branch_target = '0;
    step();
    step();
  endtask

  initial begin
    int n_req;
    int delivered;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic rdy, br;

    // Reset state and sequential streaming.
    hold_reset();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, Base);
    check("rst_valid", insn_valid, 0);
    check("rst_insn", insn_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_acc", mem_acc_size, 0);
    rst = 1'b0;
    insn_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("seq_mem_en", mem_en, 1);
      check("seq_mem_addr", mem_addr, Base + 32'(4 * i));
      if (i == 0) begin
        check("seq_first_empty", insn_valid, 0);
      end else begin
        check("seq_valid", insn_valid, 1);
        check("seq_pc", pc_out, Base + 32'(4 * (i - 1)));
        check("seq_insn", insn_out, mem_val(Base + 32'(4 * (i - 1))));
      end
    end

    // Backpressure fills the buffer with exactly DEPTH requests.
    hold_reset();
    rst = 1'b0;
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_en) n_req++;
    end
    check("stall_req_count", n_req, 4);
    check("stall_mem_en", mem_en, 0);
    check("stall_valid", insn_valid, 1);
    check("stall_head", pc_out, Base);
    insn_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("drain_valid", insn_valid, 1);
      check("drain_pc", pc_out, Base + 32'(4 * i));
      if (i == 1) check("drain_no_issue", mem_en, 0);
      if (i == 2) begin
        check("refill_en", mem_en, 1);
        check("refill_addr", mem_addr, Base + 32'd16);
      end
    end

    // Redirect with 3 buffered and one in flight, alongside a ready head.
    hold_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_br_en", mem_en, 1);
    check("pre_br_addr", mem_addr, Base + 32'd12);
    check("pre_br_head", pc_out, Base);
    branch_valid = 1'b1;
    branch_target = 32'h8002_0103;
    insn_ready = 1'b1;
    step();
    check("br_valid", insn_valid, 0);
    check("br_mem_en", mem_en, 0);
    check("br_pc_hold", pc_out, Base);
    branch_valid = 1'b0;
    step();
    check("br_issue_en", mem_en, 1);
    check("br_issue_addr", mem_addr, 32'h8002_0100);
    check("br_no_stale", insn_valid, 0);
    step();
    check("br_first_valid", insn_valid, 1);
    check("br_first_pc", pc_out, 32'h8002_0100);
    check("br_first_insn", insn_out, mem_val(32'h8002_0100));
    step();
    check("br_second_pc", pc_out, 32'h8002_0104);

    // Reset mid-fetch.
    hold_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("mid_en", mem_en, 1);
    check("mid_head", pc_out, Base);
    rst = 1'b1;
    step();
    check("mid_rst_en", mem_en, 0);
    check("mid_rst_addr", mem_addr, Base);
    check("mid_rst_valid", insn_valid, 0);
    check("mid_rst_insn", insn_out, 0);
    check("mid_rst_pc", pc_out, 0);
    rst = 1'b0;
    insn_ready = 1'b1;
    step();
    check("restart_en", mem_en, 1);
    check("restart_addr", mem_addr, Base);
    step();
    check("restart_pc", pc_out, Base);
    check("restart_insn", insn_out, mem_val(Base));

    // PC wraps through the top of the address space.
    branch_valid = 1'b1;
    branch_target = 32'hFFFF_FFFA;
    step();
    check("wrap_br_en", mem_en, 0);
    branch_valid = 1'b0;
    step();
    check("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
    step();
    check("wrap_addr1", mem_addr, 32'hFFFF_FFFC);
    check("wrap_pc0", pc_out, 32'hFFFF_FFF8);
    step();
    check("wrap_addr2", mem_addr, 32'h0000_0000);
    check("wrap_pc1", pc_out, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", pc_out, 32'h0000_0000);
    check("wrap_insn2", insn_out, mem_val(32'h0000_0000));

    // Reset beats a same-edge redirect.
    rst = 1'b1;
    branch_valid = 1'b1;
    branch_target = 32'h0000_1234;
    step();
    check("rst_br_addr", mem_addr, Base);
    check("rst_br_valid", insn_valid, 0);
    rst = 1'b0;
    branch_valid = 1'b0;
    step();
    check("rst_br_issue", mem_addr, Base);
    check("rst_br_en", mem_en, 1);

    // Random ready/redirect traffic against an in-order PC scoreboard.
    hold_reset();
    rst = 1'b0;
    exp_pc = Base;
    delivered = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      rdy = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 31) == 0);
      tgt = Base + 32'($urandom_range(0, 1023));
      insn_ready = rdy;
      branch_valid = br;
      branch_target = tgt;
      if (insn_valid && rdy && !br) begin
        check("sb_pc", pc_out, exp_pc);
        check("sb_insn", insn_out, mem_val(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (br) exp_pc = tgt & 32'hFFFF_FFFC;
      if (n_errors > 20) break;
    end
    branch_valid = 1'b0;
    insn_ready = 1'b0;
    check("sb_throughput", 32'(delivered >= 2000), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter START_ADDRESS, default 32'h80020000, is the reset fetch PC and the base of main memory.
REQ-002 Parameter DEPTH, default 4, is the prefetch buffer entries (power of two, 2..16).
REQ-003 Parameter ADDRESS_SIZE, default 32, is the address width; parameter DATA_SIZE, default 32, is the instruction width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 branch_valid  input  1  redirect request from execute.
REQ-007 branch_target  input  ADDRESS_SIZE  redirect address.
REQ-008 insn_ready  input  1  decode accepts head instruction this cycle.
REQ-009 mem_d_out  input  DATA_SIZE  read data from main memory.
REQ-010 mem_addr  output  ADDRESS_SIZE  registered read address to main memory.
REQ-011 mem_en  output  1  registered memory enable.
REQ-012 mem_wren  output  1  tied 0.
REQ-013 mem_acc_size  output  2  tied 2'b00 (single word).
REQ-014 insn_out  output  DATA_SIZE  head instruction.
REQ-015 pc_out  output  ADDRESS_SIZE  address of head instruction.
REQ-016 insn_valid  output  1  buffer non-empty; insn_out/pc_out meaningful.

Function
REQ-017 Fetch unit SHALL keep fetch_pc, a DEPTH-entry FIFO of {pc, insn}, and one in-flight flag.
REQ-018 Issue: when rst=0, branch_valid=0 and (count + inflight) < DEPTH, SHALL register mem_addr=fetch_pc, mem_en=1, set inflight, fetch_pc += 4; otherwise mem_en=0 next cycle.
REQ-019 Memory read latency is one cycle: data for a request issued at edge N (memory samples on falling edge) SHALL be captured from mem_d_out at edge N+1 and pushed with its address.
REQ-020 Issue and capture SHALL occur in the same cycle, giving one word per cycle sustained throughput.
REQ-021 Pop: insn_valid && insn_ready SHALL remove head; simultaneous push and pop SHALL leave count unchanged.
REQ-022 Full: no issue while count + inflight == DEPTH; in-flight data never dropped for lack of space.
REQ-023 Empty: insn_valid=0; insn_out/pc_out hold last value; insn_ready ignored.
REQ-024 Redirect: branch_valid=1 at edge SHALL empty FIFO, clear inflight (discarding that cycle's capture), set fetch_pc={branch_target[31:2],2'b00}, and drive mem_en=0 that cycle; issue resumes next edge.
REQ-025 branch_valid wins over simultaneous pop, push and issue.
REQ-026 fetch_pc SHALL wrap modulo 2^ADDRESS_SIZE with no error.
REQ-027 FIFO read/write pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-028 Same-edge redirect and rst: rst wins.

Reset
REQ-029 On rst=1 at edge: fetch_pc=START_ADDRESS, FIFO empty, inflight=0, mem_en=0, mem_addr=START_ADDRESS, insn_valid=0, insn_out=0, pc_out=0.
REQ-030 Reset mid-fetch SHALL discard in-flight data; first issue at first edge with rst=0.

Structure
REQ-031 START_ADDRESS, word stride 4, and access-size codes (00=1, 01=4, 10=8, 11=16 words) SHALL live in shared package mips_pkg.
REQ-032 FIFO SHALL be sub-module fetch_fifo (push, pop, flush, full, empty, count); PC/issue logic in fetch_unit.

Verification
REQ-033 Release rst, insn_ready=1, memory preloaded 0x80020000..0C -> mem_addr 0x80020000,04,08,0C on consecutive cycles; insn_valid first high two edges after release, one insn per cycle, pc_out matching.
REQ-034 insn_ready=0 for 10 cycles -> exactly 4 requests issued, mem_en=0 afterwards, count=4; re-raise -> 4 pops in order, then refill resumes.
REQ-035 branch_valid with target 0x80020103 while 3 entries buffered and one in flight -> insn_valid=0 next cycle, next mem_addr=0x80020100, no stale instruction ever presented.
REQ-036 branch_valid and insn_ready same cycle with valid head -> head not counted as consumed, FIFO flushed.
REQ-037 rst asserted with mem_en=1 and 2 entries buffered -> all outputs at REQ-029 values next edge; fetch restarts at 0x80020000.
REQ-038 Random insn_ready/branch_valid, 10k cycles -> scoreboard: delivered pc sequence equals sequential stream restarted at each redirect target, no drops, no duplicates.
